// File: rtl/vga_delay_line_if.sv
// vga_delay_line_if: control, timing-in and timing-out bundle of the VGA delay line
interface vga_delay_line_if #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 8
);
    localparam int DW = $clog2(DEPTH + 1);
    logic             ce;
    logic [DW-1:0]    delay;
    logic             in_hsync;
    logic             in_vsync;
    logic [WIDTH-1:0] in_hdata;
    logic [WIDTH-1:0] in_vdata;
    logic             in_blank;
    logic             out_hsync;
    logic             out_vsync;
    logic [WIDTH-1:0] out_hdata;
    logic [WIDTH-1:0] out_vdata;
    logic             out_blank;
    logic             out_valid;
    modport master (
        output ce, delay, in_hsync, in_vsync, in_hdata, in_vdata, in_blank,
        input  out_hsync, out_vsync, out_hdata, out_vdata, out_blank, out_valid
    );
    modport slave (
        input  ce, delay, in_hsync, in_vsync, in_hdata, in_vdata, in_blank,
        output out_hsync, out_vsync, out_hdata, out_vdata, out_blank, out_valid
    );
endinterface

// File: rtl/vga_delay_line.sv
// vga_delay_line: frame-synchronous adjustable delay (1..DEPTH ce cycles) of the VGA timing bundle
module vga_delay_line #(
    parameter int   WIDTH         = 11,
    parameter int   DEPTH         = 8,
    parameter int   DEFAULT_DELAY = 1,
    parameter logic SYNC_ACTIVE   = 1'b0
) (
    input logic clk,
    input logic rst_n,
    vga_delay_line_if.slave bus
);
    localparam int DW = $clog2(DEPTH + 1);
    localparam int BW = 2 * WIDTH + 3;
    localparam int SN = DEPTH > 1 ? DEPTH - 1 : 1;
    localparam logic [BW-1:0] IDLE = {~SYNC_ACTIVE, ~SYNC_ACTIVE, {WIDTH{1'b0}}, {WIDTH{1'b0}}, 1'b1};

    logic [BW-1:0] s [SN];
    logic [BW-1:0] tv [2**DW];
    logic [BW-1:0] inb, tap, ob;
    logic [DW-1:0] dq, fill, dc, dq_n, fill_n;
    logic          pv, fs, chg, vn, ov;

    always_comb begin
        inb = {bus.in_hsync, bus.in_vsync, bus.in_hdata, bus.in_vdata, bus.in_blank};
        dc = bus.delay == '0 ? DW'(1) : bus.delay > DW'(DEPTH) ? DW'(DEPTH) : bus.delay;
        fs = bus.in_vsync == SYNC_ACTIVE && pv != SYNC_ACTIVE;
        chg = fs && dc != dq;
        dq_n = chg ? dc : dq;
        fill_n = chg ? DW'(1) : fill >= dq ? dq : fill + DW'(1);
        vn = fill_n >= dq_n;
        for (int k = 0; k < 2**DW; k++) tv[k] = IDLE;
        tv[1] = inb;
        // tap k reaches the sample taken k-1 ce edges ago
        for (int k = 2; k <= DEPTH; k++) tv[k] = s[k-2];
        tap = tv[dq_n];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv <= ~SYNC_ACTIVE;
            dq <= DW'(DEFAULT_DELAY);
            fill <= '0;
            ov <= 1'b0;
            ob <= IDLE;
            for (int k = 0; k < SN; k++) s[k] <= IDLE;
        end else if (bus.ce) begin
            pv <= bus.in_vsync;
            dq <= dq_n;
            fill <= fill_n;
            ov <= vn;
            ob <= vn ? tap : IDLE;
            s[0] <= inb;
            for (int k = 1; k < SN; k++) s[k] <= s[k-1];
        end
    end

    assign {bus.out_hsync, bus.out_vsync, bus.out_hdata, bus.out_vdata, bus.out_blank} = ob;
    assign bus.out_valid = ov;
endmodule

// File: tb/tb_vga_delay_line.sv
// tb_vga_delay_line: randomized check of vga_delay_line against a sample-history reference model
module tb_vga_delay_line;
    localparam int   W  = 11;
    localparam int   D  = 8;
    localparam int   DD = 1;
    localparam logic SA = 1'b0;
    localparam int   DW = $clog2(D + 1);
    localparam int   BW = 2 * W + 3;
    localparam logic [BW-1:0] IDLE = {~SA, ~SA, {W{1'b0}}, {W{1'b0}}, 1'b1};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vga_delay_line_if #(.WIDTH(W), .DEPTH(D)) bus ();
    vga_delay_line #(.WIDTH(W), .DEPTH(D), .DEFAULT_DELAY(DD), .SYNC_ACTIVE(SA)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int total = 0;
    int bad = 0;
    logic [BW-1:0] hist [$];
    logic [BW-1:0] ex;
    logic exv, mpv;
    int mdq, cnt, h, v;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic mreset();
        hist.delete();
        mdq = DD;
        cnt = 0;
        mpv = ~SA;
        ex = IDLE;
        exv = 1'b0;
    endtask

    task automatic drive();
        bus.in_hdata = W'(h);
        bus.in_vdata = W'(v);
        bus.in_hsync = h >= 7 ? SA : ~SA;
        bus.in_vsync = v == 0 ? SA : ~SA;
        bus.in_blank = h >= 8 || v >= 5;
    endtask

    task automatic compare(input string tag);
        check({tag, "_bundle"}, 64'({bus.out_hsync, bus.out_vsync, bus.out_hdata, bus.out_vdata, bus.out_blank}), 64'(ex));
        check({tag, "_valid"}, 64'(bus.out_valid), 64'(exv));
    endtask

    // model: a sample is delivered once dq samples have been taken since reset or the last accepted change
    task automatic cyc(input logic c, input int dl);
        int dc;
        logic fs;
        bus.ce = c;
        bus.delay = DW'(dl);
        drive();
        @(posedge clk);
        if (c && rst_n) begin
            dc = dl == 0 ? 1 : dl > D ? D : dl;
            fs = bus.in_vsync == SA && mpv != SA;
            mpv = bus.in_vsync;
            hist.push_back({bus.in_hsync, bus.in_vsync, bus.in_hdata, bus.in_vdata, bus.in_blank});
            if (hist.size() > 80) void'(hist.pop_front());
            if (fs && dc != mdq) begin
                mdq = dc;
                cnt = 1;
            end else cnt++;
            exv = cnt >= mdq;
            ex = exv ? hist[hist.size() - mdq] : IDLE;
        end
        if (c) begin
            h++;
            if (h == 10) begin
                h = 0;
                v = (v + 1) % 6;
            end
        end
        #1 compare("cyc");
    endtask

    task automatic run(input int n, input int dl, input int pct);
        for (int i = 0; i < n; i++) cyc($urandom_range(99) < pct, dl);
    endtask

    initial begin
        mreset();
        h = 0;
        v = 3;
        bus.ce = 1'b1;
        bus.delay = DW'(DD);
        drive();
        #12 compare("in_reset");
        @(negedge clk) rst_n = 1'b1;
        run(55, 1, 100);
        run(150, 5, 100);
        run(130, 5, 100);
        run(130, 0, 100);
        run(130, D + 3, 100);
        for (int i = 0; i < 180; i++) cyc(i % 3 == 0, 3);
        run(200, 3, 60);
        run(150, 3, 100);
        run(150, 4, 100);
        #2 rst_n = 1'b0;
        #1 begin
            mreset();
            compare("async_reset");
        end
        cyc(1'b1, 4);
        cyc(1'b1, 4);
        @(negedge clk) rst_n = 1'b1;
        run(150, 4, 100);
        for (int i = 0; i < 12; i++) run(80, $urandom_range(0, D + 3), $urandom_range(50, 100));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vga_delay_line.md
# vga_delay_line

Parametrised, run-time adjustable delay line for the VGA timing bundle: hsync, vsync, horizontal/vertical counters and blank. It sits between the timing generator and the pixel pipeline and re-aligns timing with pixel data by 1..DEPTH pixel-clock-enable cycles. Delay changes are applied only at frame start. Outputs are held at idle levels until the pipeline has refilled.

## Interface
- WIDTH, 11, width of the hdata/vdata counter buses (must be ≥1)
- DEPTH, 8, maximum delay in ce cycles (1..64)
- DEFAULT_DELAY, 1, delay in effect after reset (1..DEPTH)
- SYNC_ACTIVE, 0, active level of hsync/vsync; idle level is ~SYNC_ACTIVE

- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- ce  input  1  pixel clock enable; all state advances only when ce=1
- delay  input  DW=$clog2(DEPTH+1)  requested delay in ce cycles
- in_hsync  input  1  horizontal sync
- in_vsync  input  1  vertical sync
- in_hdata  input  WIDTH  horizontal counter
- in_vdata  input  WIDTH  vertical counter
- in_blank  input  1  blanking, 1 = blank
- out_hsync  output  1  delayed hsync (registered)
- out_vsync  output  1  delayed vsync (registered)
- out_hdata  output  WIDTH  delayed horizontal counter (registered)
- out_vdata  output  WIDTH  delayed vertical counter (registered)
- out_blank  output  1  delayed blank (registered)
- out_valid  output  1  1 = outputs carry real delayed input (registered)

## Operation
- Stage chain s[1..DEPTH-1] of the full bundle. On ce: s[1]<=in, s[k]<=s[k-1]. The output register is the final stage.
- Tap: dq==1 selects in; otherwise s[dq-1]. Latency is therefore exactly dq ce cycles.
- Clamp: requested delay 0 maps to 1; delay>DEPTH maps to DEPTH. Call the clamped value dc.
- Frame start: a ce cycle where in_vsync==SYNC_ACTIVE and the previous ce-sampled vsync != SYNC_ACTIVE. The previous-vsync register resets to idle.
- On frame start with dc != dq:
  - dq<=dc, fill<=1.
  - The frame-start sample is sample 1 under the new delay.
- On frame start with dc==dq: no effect, no flush.
- Delay changes between frame starts are ignored until the next frame start.
- Fill counter: range 0..DEPTH, reset 0. On ce without a change, fill<=min(fill+1, dq).
- valid_next = (new fill ≥ new dq). On ce, out_valid<=valid_next.
- Output register on ce:
  - If valid_next: loads the tap, using the new dq on a change cycle.
  - Otherwise: loads idle values (sync=~SYNC_ACTIVE, data=0, blank=1).
- ce=0: all registers hold.

## Timing
- Reset values (async, immediate):
  - out_hsync=out_vsync=~SYNC_ACTIVE, out_hdata=out_vdata=0, out_blank=1, out_valid=0.
  - All stages at idle values, fill=0, dq=DEFAULT_DELAY.
- After reset: out_valid rises on the DEFAULT_DELAY-th ce edge. That edge also loads the output with the sample taken at ce #1.
- After an accepted change to dq=N: out_valid drops on the frame-start edge (unless N==1) and rises on the N-th ce edge counting frame start as #1. At that edge out_vsync shows the frame-start vsync edge.
- Stage contents are not cleared on a change. Only the output is gated by out_valid.
- Reset asserted mid-frame: immediate return to reset values. The first frame start after reset may then apply a new delay.
- Simultaneous reset release and ce: the first ce edge after release counts as ce #1.

## Test plan
- Reset, DEFAULT_DELAY=1, ce=1, ramp in_hdata 0,1,2… -> out_valid=1 after edge 1; out_hdata equals in_hdata from the previous cycle. During reset: outputs idle, blank=1, syncs=~SYNC_ACTIVE.
- delay=5 set mid-frame -> no change until the next vsync active edge. Then out_valid=0 for 4 ce edges and rises at the 5th. out_vsync asserts active on that same edge. Subsequent latency is 5.
- delay=0 and delay=DEPTH+3 -> behave as 1 and DEPTH respectively; verify latency with the hdata ramp.
- ce toggled 1,0,0,1,… with delay=3 -> latency is 3 ce-enabled cycles; outputs and out_valid hold while ce=0.
- Same delay rewritten at frame start -> out_valid stays 1 and the output stream is uninterrupted.
- rst_n pulsed low mid-frame at delay=4 -> outputs go idle immediately (asynchronously). dq=DEFAULT_DELAY after release. out_valid returns after DEFAULT_DELAY ce edges.
